// File: rtl/cam_cfg_sequencer_if.sv
// SCCB write-request channel between the config sequencer and the SCCB master.
//   sccb_req   : write request, held until accepted (req & ready)
//   sccb_reg   : register address, stable while req is high
//   sccb_val   : register value, stable while req is high
//   sccb_ready : master accepts the request in a cycle where req & ready
//   sccb_done  : one-cycle pulse when the accepted write completes
//   sccb_nack  : valid with sccb_done, 1 = slave NACK
// master modport = sequencer side, slave modport = SCCB master side.
interface cam_cfg_sequencer_if;
    logic       sccb_req;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_val;
    logic       sccb_ready;
    logic       sccb_done;
    logic       sccb_nack;

    modport master (
        output sccb_req, sccb_reg, sccb_val,
        input  sccb_ready, sccb_done, sccb_nack
    );

    modport slave (
        input  sccb_req, sccb_reg, sccb_val,
        output sccb_ready, sccb_done, sccb_nack
    );
endinterface

// File: rtl/cam_cfg_sequencer.sv
// Camera register-configuration sequencer. Walks one profile of an external
// synchronous config ROM (address {profile, index}) and turns each 16-bit
// entry {reg, val} into an SCCB write, a timed delay (reg == FF) or the end
// of table (FFFF).
// Optional feature macro: CAM_CFG_RETRY_EN -- a NACKed write is re-issued up
// to MAX_RETRY times before error is flagged; MAX_RETRY exists only then.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   start            : one-cycle pulse, accepted only when idle
//   profile_sel      : profile number latched on an accepted start
//   rom_addr         : ROM read address {profile, index}
//   rom_data         : ROM word, valid ROM_LAT cycles after rom_addr
//   sccb             : SCCB write channel (master side)
//   busy             : sequence in progress
//   done             : sequence finished, sticky until the next start
//   error            : NACK or missing terminator, sticky until the next start
//   entry_cnt        : number of register writes completed
module cam_cfg_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned PROFILE_W  = 1,
    parameter int unsigned ROM_LAT    = 1,
`ifdef CAM_CFG_RETRY_EN
    parameter int unsigned MAX_RETRY  = 3,
`endif
    parameter int unsigned DELAY_UNIT = 100000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic [PROFILE_W-1:0]        profile_sel,
    output logic [PROFILE_W+ADDR_W-1:0] rom_addr,
    input  logic [15:0]                 rom_data,
    cam_cfg_sequencer_if.master         sccb,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [ADDR_W-1:0]           entry_cnt
);

    // val * DELAY_UNIT always fits in 8 + clog2(DELAY_UNIT) bits
    localparam int unsigned DLY_W    = 8 + $clog2(DELAY_UNIT);
    localparam int unsigned LAT_W    = 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);
`ifdef CAM_CFG_RETRY_EN
    localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

    // Finishing a sequence drops straight back to IDLE with done set.
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_WRITE, ST_WAIT, ST_DELAY, ST_NEXT
    } state_t;

    state_t                        state_q, state_d;
    logic [PROFILE_W-1:0]          profile_q, profile_d;
    logic [ADDR_W-1:0]             index_q, index_d;
    logic [LAT_W-1:0]              lat_q, lat_d;
    logic [DLY_W-1:0]              dly_q, dly_d;
    logic                          req_q, req_d;
    logic [7:0]                    reg_q, reg_d;
    logic [7:0]                    val_q, val_d;
    logic [PROFILE_W+ADDR_W-1:0]   rom_addr_d;
    logic                          busy_d, done_d, error_d;
    logic [ADDR_W-1:0]             entry_cnt_d;
`ifdef CAM_CFG_RETRY_EN
    logic [RTY_W-1:0]              retry_q, retry_d;
`endif

    assign sccb.sccb_req = req_q;
    assign sccb.sccb_reg = reg_q;
    assign sccb.sccb_val = val_q;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        profile_d   = profile_q;
        index_d     = index_q;
        lat_d       = lat_q;
        dly_d       = dly_q;
        req_d       = req_q;
        reg_d       = reg_q;
        val_d       = val_q;
        rom_addr_d  = rom_addr;
        busy_d      = busy;
        done_d      = done;
        error_d     = error;
        entry_cnt_d = entry_cnt;
`ifdef CAM_CFG_RETRY_EN
        retry_d     = retry_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    profile_d   = profile_sel;
                    index_d     = '0;
                    entry_cnt_d = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    rom_addr_d  = {profile_sel, ADDR_W'(0)};
                    lat_d       = '0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_DECODE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_DECODE: begin
`ifdef CAM_CFG_RETRY_EN
                retry_d = '0;
`endif
                if (rom_data == 16'hFFFF) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (rom_data[15:8] == 8'hFF) begin
                    // Counter runs val*DELAY_UNIT cycles; val 0 still takes one
                    if (rom_data[7:0] == 8'h00) begin
                        dly_d = '0;
                    end else begin
                        dly_d = DLY_W'(rom_data[7:0]) * DLY_W'(DELAY_UNIT) - DLY_W'(1);
                    end
                    state_d = ST_DELAY;
                end else begin
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    req_d   = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A done seen here precedes acceptance and is ignored
                if (sccb.sccb_ready) begin
                    req_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sccb.sccb_done) begin
                    if (!sccb.sccb_nack) begin
                        entry_cnt_d = entry_cnt + ADDR_W'(1);
                        state_d     = ST_NEXT;
                    end else begin
`ifdef CAM_CFG_RETRY_EN
                        if (retry_q < RTY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RTY_W'(1);
                            req_d   = 1'b1;
                            state_d = ST_WRITE;
                        end else begin
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
`else
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_DELAY: begin
                if (dly_q == '0) begin
                    state_d = ST_NEXT;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ST_NEXT: begin
                // Running off the end of the profile means no terminator
                if (index_q == '1) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    index_d    = index_q + ADDR_W'(1);
                    rom_addr_d = {profile_q, index_q + ADDR_W'(1)};
                    lat_d      = '0;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            profile_q <= '0;
            index_q   <= '0;
            lat_q     <= '0;
            dly_q     <= '0;
            req_q     <= 1'b0;
            reg_q     <= '0;
            val_q     <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            entry_cnt <= '0;
`ifdef CAM_CFG_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            profile_q <= profile_d;
            index_q   <= index_d;
            lat_q     <= lat_d;
            dly_q     <= dly_d;
            req_q     <= req_d;
            reg_q     <= reg_d;
            val_q     <= val_d;
            rom_addr  <= rom_addr_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            entry_cnt <= entry_cnt_d;
`ifdef CAM_CFG_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Self-checking bench for cam_cfg_sequencer: ROM model, SCCB slave model with
// a write scoreboard, and one task per scenario.
module tb_cam_cfg_sequencer;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned PROFILE_W  = 1;
    localparam int unsigned ROM_LAT    = 1;
    localparam int unsigned DELAY_UNIT = 10;
    localparam int unsigned AW         = ADDR_W + PROFILE_W;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [PROFILE_W-1:0] profile_sel = '0;
    logic [AW-1:0]        rom_addr;
    logic [15:0]          rom_data;
    logic                 busy, done, error;
    logic [ADDR_W-1:0]    entry_cnt;

    cam_cfg_sequencer_if sif();

    cam_cfg_sequencer #(
        .ADDR_W     (ADDR_W),
        .PROFILE_W  (PROFILE_W),
        .ROM_LAT    (ROM_LAT),
        .DELAY_UNIT (DELAY_UNIT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .profile_sel (profile_sel),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb        (sif),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .entry_cnt   (entry_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle latency
    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];
    bit          nack_q [$];
    int          bp_cfg = 0;
    int          req_accepts = 0;
    int          stall_seen = 0;

    // SCCB slave: accepts on req&ready, pulses done 4 cycles later,
    // optionally stalls ready for bp_cfg cycles on every new request.
    int          done_timer = 0;
    int          bp_left = 0;
    bit          acc_pend = 0;
    bit          prev_req = 0;
    logic [15:0] held = '0;
    logic [15:0] e;
    always @(negedge clk) begin
        if (!rstn) begin
            done_timer = 0;
            bp_left = 0;
            acc_pend = 0;
            prev_req = 0;
            sif.sccb_done = 1'b0;
            sif.sccb_nack = 1'b0;
            sif.sccb_ready = 1'b1;
        end else begin
            sif.sccb_done = 1'b0;
            sif.sccb_nack = 1'b0;
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) begin
                    sif.sccb_done = 1'b1;
                    sif.sccb_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                end
            end
            if (acc_pend) begin
                acc_pend = 0;
                done_timer = 3;
            end
            if (sif.sccb_req && !prev_req) begin
                bp_left = bp_cfg;
                held = {sif.sccb_reg, sif.sccb_val};
            end
            if (sif.sccb_req && bp_left > 0) begin
                sif.sccb_ready = 1'b0;
                bp_left--;
                stall_seen++;
                n_checks++;
                if ({sif.sccb_reg, sif.sccb_val} !== held) begin
                    n_fail++;
                    $display("FAIL stall_data: got %h expected %h", {sif.sccb_reg, sif.sccb_val}, held);
                end
            end else begin
                sif.sccb_ready = 1'b1;
            end
            if (sif.sccb_req && sif.sccb_ready) begin
                acc_pend = 1;
                req_accepts++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_write: got %h expected none", {sif.sccb_reg, sif.sccb_val});
                end else begin
                    e = exp_q.pop_front();
                    if ({sif.sccb_reg, sif.sccb_val} !== e) begin
                        n_fail++;
                        $display("FAIL sb_write: got %h expected %h", {sif.sccb_reg, sif.sccb_val}, e);
                    end
                end
            end
            prev_req = sif.sccb_req;
        end
    end

    // Sample/drive point: 1 after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    endtask

    // Returns at the first sample point after the accepting edge
    task automatic pulse_start(input logic [PROFILE_W-1:0] prof);
        start = 1'b1;
        profile_sel = prof;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rst_rom_addr: got %h expected 0", rom_addr); end
        n_checks++; if (sif.sccb_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", sif.sccb_req); end
        n_checks++; if ({sif.sccb_reg, sif.sccb_val} !== 16'h0) begin n_fail++; $display("FAIL rst_regval: got %h expected 0", {sif.sccb_reg, sif.sccb_val}); end
        n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {busy, done, error}); end
        n_checks++; if (entry_cnt !== '0) begin n_fail++; $display("FAIL rst_entry_cnt: got %0d expected 0", entry_cnt); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int cyc;
        int acc0;
        bit ok;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        acc0 = req_accepts;
        pulse_start(1'b0);
        n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL basic_busy: got %b expected 10", {busy, done}); end
        cyc = 1;
        while (!sif.sccb_req && cyc < 50) begin tick(); cyc++; end
        n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL basic_req_latency: got %0d expected 3", cyc); end
        wait_finish(300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got 0 expected 1"); end
        n_checks++; if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL basic_flags: got %b expected 10", {done, error}); end
        n_checks++; if (entry_cnt !== 3'd2) begin n_fail++; $display("FAIL basic_entry_cnt: got %0d expected 2", entry_cnt); end
        n_checks++; if (req_accepts - acc0 != 2 || exp_q.size() != 0) begin n_fail++; $display("FAIL basic_writes: got %0d expected 2", req_accepts - acc0); end
    endtask

    task automatic test_delay();
        int vals [2] = '{5, 0};
        int cyc, changes, expd;
        logic [AW-1:0] a;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            clear_rom();
            rom[0] = 16'h1280; rom[1] = {8'hFF, 8'(vals[k])}; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
            exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
            pulse_start(1'b0);
            cyc = 0;
            while (!sif.sccb_done && cyc < 200) begin tick(); cyc++; end
            // NEXT, FETCH, DECODE, then the delay, then NEXT before the address moves
            expd = 5 + ((vals[k] == 0) ? 1 : vals[k] * int'(DELAY_UNIT));
            a = rom_addr; cyc = 0; changes = 0;
            while (changes < 2 && cyc < 2000) begin
                tick(); cyc++;
                if (rom_addr !== a) begin changes++; a = rom_addr; end
            end
            n_checks++; if (cyc != expd) begin n_fail++; $display("FAIL delay_gap_%0d: got %0d expected %0d", vals[k], cyc, expd); end
            wait_finish(300, ok);
            n_checks++; if (!ok || entry_cnt !== 3'd2 || error !== 1'b0) begin n_fail++; $display("FAIL delay_end_%0d: got cnt %0d err %b expected cnt 2 err 0", vals[k], entry_cnt, error); end
        end
    endtask

    task automatic test_profile();
        int msb_bad;
        bit ok;
        clear_rom();
        rom[8] = 16'h1322; rom[9] = 16'hFFFF;
        exp_q.push_back(16'h1322);
        pulse_start(1'b1);
        n_checks++; if (rom_addr !== 4'h8) begin n_fail++; $display("FAIL profile_addr: got %h expected 8", rom_addr); end
        profile_sel = 1'b0;
        msb_bad = 0; ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rom_addr[AW-1] !== 1'b1) msb_bad++;
            if (done && !busy) begin ok = 1; break; end
        end
        n_checks++; if (msb_bad != 0 || !ok) begin n_fail++; $display("FAIL profile_msb: got %0d low cycles expected 0", msb_bad); end
        n_checks++; if (entry_cnt !== 3'd1 || exp_q.size() != 0) begin n_fail++; $display("FAIL profile_cnt: got %0d expected 1", entry_cnt); end
    endtask

    task automatic test_nack();
        int acc0, exp_acc, exp_cnt;
        bit ok, exp_err;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1002; rom[3] = 16'hFFFF;
`ifdef CAM_CFG_RETRY_EN
        exp_q.push_back(16'h1280);
        repeat (3) exp_q.push_back(16'h1101);
        exp_q.push_back(16'h1002);
        nack_q.push_back(0); nack_q.push_back(1); nack_q.push_back(1); nack_q.push_back(0); nack_q.push_back(0);
        exp_acc = 5; exp_cnt = 3; exp_err = 0;
`else
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        nack_q.push_back(0); nack_q.push_back(1);
        exp_acc = 2; exp_cnt = 1; exp_err = 1;
`endif
        acc0 = req_accepts;
        pulse_start(1'b0);
        wait_finish(500, ok);
        n_checks++; if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL nack_done: got %b expected 1", done); end
        n_checks++; if (error !== exp_err) begin n_fail++; $display("FAIL nack_error: got %b expected %b", error, exp_err); end
        n_checks++; if (entry_cnt !== ADDR_W'(exp_cnt)) begin n_fail++; $display("FAIL nack_entry_cnt: got %0d expected %0d", entry_cnt, exp_cnt); end
        n_checks++; if (req_accepts - acc0 != exp_acc || exp_q.size() != 0) begin n_fail++; $display("FAIL nack_reqs: got %0d expected %0d", req_accepts - acc0, exp_acc); end
        nack_q.delete();
    endtask

    task automatic test_backpressure();
        int st0;
        bit ok;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        st0 = stall_seen;
        bp_cfg = 20;
        pulse_start(1'b0);
        wait_finish(500, ok);
        bp_cfg = 0;
        n_checks++; if (stall_seen - st0 != 40) begin n_fail++; $display("FAIL bp_stalls: got %0d expected 40", stall_seen - st0); end
        n_checks++; if (!ok || {done, error} !== 2'b10 || entry_cnt !== 3'd2) begin n_fail++; $display("FAIL bp_end: got de %b cnt %0d expected de 10 cnt 2", {done, error}, entry_cnt); end
    endtask

    task automatic test_terminator();
        logic [15:0] tbl [8] = '{16'h1280, 16'h1101, 16'hFF00, 16'h1002, 16'h1303, 16'hFF00, 16'h1404, 16'h1505};
        int acc0;
        bit ok;
        clear_rom();
        for (int i = 0; i < 8; i++) begin
            rom[i] = tbl[i];
            if (tbl[i][15:8] != 8'hFF) exp_q.push_back(tbl[i]);
        end
        acc0 = req_accepts;
        pulse_start(1'b0);
        wait_finish(1000, ok);
        n_checks++; if (!ok || {done, error} !== 2'b11) begin n_fail++; $display("FAIL term_flags: got %b expected 11", {done, error}); end
        n_checks++; if (entry_cnt !== 3'd6 || req_accepts - acc0 != 6) begin n_fail++; $display("FAIL term_cnt: got %0d expected 6", entry_cnt); end
        n_checks++; if (rom_addr !== 4'h7) begin n_fail++; $display("FAIL term_last_addr: got %h expected 7", rom_addr); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        pulse_start(1'b0);
        cyc = 0;
        while (entry_cnt !== 3'd1 && cyc < 200) begin tick(); cyc++; end
        bp_cfg = 1000;
        while (!sif.sccb_req && cyc < 400) begin tick(); cyc++; end
        n_checks++; if (sif.sccb_req !== 1'b1 || entry_cnt !== 3'd1) begin n_fail++; $display("FAIL rmid_setup: got req %b cnt %0d expected req 1 cnt 1", sif.sccb_req, entry_cnt); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if ({sif.sccb_req, busy, done, error} !== 4'b0000) begin n_fail++; $display("FAIL rmid_async: got %b expected 0000", {sif.sccb_req, busy, done, error}); end
        n_checks++; if (entry_cnt !== '0) begin n_fail++; $display("FAIL rmid_entry_cnt: got %0d expected 0", entry_cnt); end
        exp_q.delete();
        nack_q.delete();
        bp_cfg = 0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_restart();
        int msb_bad, acc0;
        bit ok;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
`ifdef CAM_CFG_RETRY_EN
        repeat (4) begin exp_q.push_back(16'h1280); nack_q.push_back(1); end
`else
        exp_q.push_back(16'h1280); nack_q.push_back(1);
`endif
        pulse_start(1'b0);
        wait_finish(500, ok);
        n_checks++; if (!ok || {done, error} !== 2'b11) begin n_fail++; $display("FAIL rs_first: got %b expected 11", {done, error}); end
        nack_q.delete();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1101);
        acc0 = req_accepts;
        pulse_start(1'b0);
        n_checks++; if ({busy, done, error} !== 3'b100 || rom_addr !== 4'h0) begin n_fail++; $display("FAIL rs_cleared: got %b addr %h expected 100 addr 0", {busy, done, error}, rom_addr); end
        repeat (3) tick();
        pulse_start(1'b1);
        profile_sel = 1'b0;
        msb_bad = 0; ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rom_addr[AW-1] !== 1'b0) msb_bad++;
            if (done && !busy) begin ok = 1; break; end
        end
        n_checks++; if (!ok || msb_bad != 0) begin n_fail++; $display("FAIL rs_busy_start: got %0d profile-1 cycles expected 0", msb_bad); end
        n_checks++; if (entry_cnt !== 3'd2 || error !== 1'b0 || req_accepts - acc0 != 2) begin n_fail++; $display("FAIL rs_end: got cnt %0d err %b expected cnt 2 err 0", entry_cnt, error); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();
        test_reset();
        test_basic();
        test_delay();
        test_profile();
        test_nack();
        test_backpressure();
        test_terminator();
        test_reset_mid();
        test_restart();
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
